ft_alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 3-bit fault-tolerant dual-output add/subtract ALU.
- Checks operand parity and one-hot control, then conditions operands (two's-complement negate).
- Computes the result in two independent lanes (X, Y). Each lane uses a duplicated adder with sum-parity prediction and two-rail error outputs.
- Adds a valid/ready handshake, a two-stage register pipeline, and a health state machine with a sticky FAILED state. Sits between the operand source and the result consumer.

---
 rtl/ft_alu_pkg.sv | 21 ++
 rtl/ft_alu_pipe_if.sv | 31 +++
 rtl/ft_alu_lane.sv | 43 ++++
 rtl/ft_alu_pipe.sv | 242 ++++++++++++++++++++++++
 tb/tb_ft_alu_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft_alu_pkg.sv
// Shared types and constants for the fault-tolerant pipelined add/subtract ALU.
package ft_alu_pkg;

  typedef enum logic [1:0] {
    HEALTHY = 2'b00,
    SUSPECT = 2'b01,
    FAILED  = 2'b10
  } health_e;

  localparam logic [1:0] TR_OK  = 2'b01;
  localparam logic [1:0] TR_ERR = 2'b11;

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB_B = 3'b010;
  localparam logic [2:0] OP_SUB_A = 3'b100;

  function automatic logic ctl_is_onehot(logic [2:0] ctl);
    return (ctl == OP_ADD) || (ctl == OP_SUB_B) || (ctl == OP_SUB_A);
  endfunction

endpackage

// File: rtl/ft_alu_pipe_if.sv
// Operand and result handshake bundle. The master is the source/consumer side and the slave is the ALU.
interface ft_alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_par;
  logic             b_par;
  logic [2:0]       ctl;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             xc;
  logic             yc;
  logic [1:0]       xe;
  logic [1:0]       ye;

  modport master (
    output in_valid, a, b, a_par, b_par, ctl, out_ready,
    input  in_ready, out_valid, x, y, xc, yc, xe, ye
  );

  modport slave (
    input  in_valid, a, b, a_par, b_par, ctl, out_ready,
    output in_ready, out_valid, x, y, xc, yc, xe, ye
  );
endinterface

// File: rtl/ft_alu_lane.sv
// One self-checking lane: primary and duplicate ripple adders, sum-parity predictor and comparator.
module ft_alu_lane #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_err,
  input  logic             ctl_err,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err
);
  logic [WIDTH:0]   pri_c;
  logic [WIDTH:0]   dup_c;
  logic [WIDTH-1:0] dup_sum;
  logic             dup_cin;
  logic             pred_par;

  // Kept as a named net so the duplicate's carry-in is observable on its own.
  assign dup_cin = 1'b0;

  always_comb begin
    pri_c    = '0;
    dup_c    = '0;
    sum      = '0;
    dup_sum  = '0;
    dup_c[0] = dup_cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ pri_c[i];
      pri_c[i+1]   = (a[i] & b[i]) | (pri_c[i] & (a[i] ^ b[i]));
      dup_sum[i]   = a[i] ^ b[i] ^ dup_c[i];
      dup_c[i+1]   = (a[i] & b[i]) | (dup_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = pri_c[WIDTH];
  // Parity of a sum equals parity of its operands xor the carries into each bit.
  assign pred_par = (^a) ^ (^b) ^ (^pri_c[WIDTH-1:0]);

  assign err = (sum != dup_sum) | (pri_c[WIDTH] != dup_c[WIDTH]) | (pred_par != ^sum) |
               in_err | ctl_err;

endmodule

// File: rtl/ft_alu_pipe.sv
// Two-stage pipelined fault-tolerant add/subtract ALU with health tracking.
// Define FT_ALU_ERRLOG_EN to build the first-error log; otherwise the log ports read 0.
module ft_alu_pipe
  import ft_alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned CLEAN_RUN  = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  ft_alu_pipe_if.slave     bus,
  input  logic             clr_fail,
  output logic [1:0]       health,
  output logic [CNT_W-1:0] err_cnt,
  output logic             log_valid,
  output logic [WIDTH-1:0] log_a,
  output logic [WIDTH-1:0] log_b,
  output logic [2:0]       log_ctl
);
  localparam int unsigned RunMax = (ERR_THRESH > CLEAN_RUN) ? ERR_THRESH : CLEAN_RUN;
  localparam int unsigned RunW   = $clog2(RunMax + 1);

  logic             s1_full_q, s1_in_err_q, s1_ctl_err_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s2_full_q, s2_xc_q, s2_yc_q, s2_xerr_q, s2_yerr_q;
  logic [WIDTH-1:0] s2_x_q, s2_y_q;

  logic             s1_adv, s2_adv, accept, deliver, res_err;
  logic [WIDTH-1:0] a_cond, b_cond;
  logic             in_err, ctl_err;
  logic [WIDTH-1:0] x_sum, y_sum;
  logic             x_cout, y_cout, x_err, y_err;
  logic [1:0]       lane_xe, lane_ye;

  health_e          health_q, health_d;
  logic [RunW-1:0]  err_run_q, err_run_d, clean_run_q, clean_run_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign s2_adv       = !s2_full_q | bus.out_ready;
  assign s1_adv       = !s1_full_q | s2_adv;
  assign accept       = bus.in_valid & s1_adv;
  assign deliver      = s2_full_q & bus.out_ready;
  assign bus.in_ready = s1_adv;

  always_comb begin
    a_cond  = bus.ctl[2] ? (~bus.a + WIDTH'(1)) : bus.a;
    b_cond  = bus.ctl[1] ? (~bus.b + WIDTH'(1)) : bus.b;
    in_err  = (bus.a_par != ^bus.a) | (bus.b_par != ^bus.b);
    ctl_err = !ctl_is_onehot(bus.ctl);
  end

  ft_alu_lane #(.WIDTH(WIDTH)) u_lane_x (
    .a       (s1_a_q),
    .b       (s1_b_q),
    .in_err  (s1_in_err_q),
    .ctl_err (s1_ctl_err_q),
    .sum     (x_sum),
    .cout    (x_cout),
    .err     (x_err)
  );

  ft_alu_lane #(.WIDTH(WIDTH)) u_lane_y (
    .a       (s1_a_q),
    .b       (s1_b_q),
    .in_err  (s1_in_err_q),
    .ctl_err (s1_ctl_err_q),
    .sum     (y_sum),
    .cout    (y_cout),
    .err     (y_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full_q    <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_in_err_q  <= 1'b0;
      s1_ctl_err_q <= 1'b0;
      s2_full_q    <= 1'b0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      s2_xc_q      <= 1'b0;
      s2_yc_q      <= 1'b0;
      s2_xerr_q    <= 1'b0;
      s2_yerr_q    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_full_q <= bus.in_valid;
        if (accept) begin
          s1_a_q       <= a_cond;
          s1_b_q       <= b_cond;
          s1_in_err_q  <= in_err;
          s1_ctl_err_q <= ctl_err;
        end
      end
      if (s2_adv) begin
        s2_full_q <= s1_full_q;
        if (s1_full_q) begin
          s2_x_q    <= x_sum;
          s2_y_q    <= y_sum;
          s2_xc_q   <= x_cout;
          s2_yc_q   <= y_cout;
          s2_xerr_q <= x_err;
          s2_yerr_q <= y_err;
        end
      end
    end
  end

  assign bus.out_valid = s2_full_q;
  assign bus.x         = s2_x_q;
  assign bus.y         = s2_y_q;
  assign bus.xc        = s2_xc_q;
  assign bus.yc        = s2_yc_q;
  assign bus.xe        = lane_xe;
  assign bus.ye        = lane_ye;
  assign res_err       = (lane_xe == TR_ERR) | (lane_ye == TR_ERR);

  // Health FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      health_q    <= HEALTHY;
      err_run_q   <= '0;
      clean_run_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      health_q    <= health_d;
      err_run_q   <= err_run_d;
      clean_run_q <= clean_run_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Health FSM: next state. The error that enters SUSPECT counts as the first of its run.
  always_comb begin
    health_d    = health_q;
    err_run_d   = err_run_q;
    clean_run_d = clean_run_q;
    err_cnt_d   = err_cnt_q;
    if (clr_fail) begin
      health_d    = HEALTHY;
      err_run_d   = '0;
      clean_run_d = '0;
      err_cnt_d   = '0;
    end else if (deliver) begin
      if (res_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
      unique case (health_q)
        HEALTHY: begin
          if (res_err) begin
            health_d    = SUSPECT;
            err_run_d   = RunW'(1);
            clean_run_d = '0;
          end
        end
        SUSPECT: begin
          if (res_err) begin
            clean_run_d = '0;
            if (err_run_q >= RunW'(ERR_THRESH - 1)) begin
              health_d  = FAILED;
              err_run_d = '0;
            end else begin
              err_run_d = err_run_q + RunW'(1);
            end
          end else begin
            err_run_d = '0;
            if (clean_run_q >= RunW'(CLEAN_RUN - 1)) begin
              health_d    = HEALTHY;
              clean_run_d = '0;
            end else begin
              clean_run_d = clean_run_q + RunW'(1);
            end
          end
        end
        FAILED:  ;
        default: health_d = FAILED;
      endcase
    end
  end

  // Health FSM: outputs. FAILED poisons both lanes while data keeps flowing.
  always_comb begin
    health  = health_q;
    err_cnt = err_cnt_q;
    lane_xe = ((health_q == FAILED) || s2_xerr_q) ? TR_ERR : TR_OK;
    lane_ye = ((health_q == FAILED) || s2_yerr_q) ? TR_ERR : TR_OK;
  end

`ifdef FT_ALU_ERRLOG_EN
  logic [WIDTH-1:0] s1_raw_a_q, s1_raw_b_q, s2_raw_a_q, s2_raw_b_q, log_a_q, log_b_q;
  logic [2:0]       s1_raw_ctl_q, s2_raw_ctl_q, log_ctl_q;
  logic             log_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_raw_a_q   <= '0;
      s1_raw_b_q   <= '0;
      s1_raw_ctl_q <= '0;
      s2_raw_a_q   <= '0;
      s2_raw_b_q   <= '0;
      s2_raw_ctl_q <= '0;
    end else begin
      if (accept) begin
        s1_raw_a_q   <= bus.a;
        s1_raw_b_q   <= bus.b;
        s1_raw_ctl_q <= bus.ctl;
      end
      if (s2_adv && s1_full_q) begin
        s2_raw_a_q   <= s1_raw_a_q;
        s2_raw_b_q   <= s1_raw_b_q;
        s2_raw_ctl_q <= s1_raw_ctl_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_fail) begin
      log_valid_q <= 1'b0;
      log_a_q     <= '0;
      log_b_q     <= '0;
      log_ctl_q   <= '0;
    end else if (deliver && res_err && !log_valid_q) begin
      log_valid_q <= 1'b1;
      log_a_q     <= s2_raw_a_q;
      log_b_q     <= s2_raw_b_q;
      log_ctl_q   <= s2_raw_ctl_q;
    end
  end

  assign log_valid = log_valid_q;
  assign log_a     = log_a_q;
  assign log_b     = log_b_q;
  assign log_ctl   = log_ctl_q;
`else
  assign log_valid = 1'b0;
  assign log_a     = '0;
  assign log_b     = '0;
  assign log_ctl   = '0;
`endif

endmodule

// File: tb/tb_ft_alu_pipe.sv
// Directed bench for ft_alu_pipe: arithmetic/health reference model plus literal spot checks.
module tb_ft_alu_pipe;
  import ft_alu_pkg::*;

  typedef struct {
    logic [7:0] x;
    logic       c;
    logic       xerr;
    logic       yerr;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] ctl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_fail;
  logic [1:0] health;
  logic [7:0] err_cnt;
  logic       log_valid;
  logic [7:0] log_a, log_b;
  logic [2:0] log_ctl;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;
  bit fault_x = 1'b0;
  bit saw_stall = 1'b0;

  exp_t q[$];
  exp_t ce;
  int   mh, erun, crun, mcnt;
  bit   mlog_v;
  logic [7:0] mlog_a, mlog_b;
  logic [2:0] mlog_c;
  bit   xerr_e, yerr_e;

  always #5 clk = ~clk;

  ft_alu_pipe_if #(.WIDTH(8)) bus ();

  ft_alu_pipe #(
    .WIDTH      (8),
    .ERR_THRESH (3),
    .CLEAN_RUN  (4),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_fail  (clr_fail),
    .health    (health),
    .err_cnt   (err_cnt),
    .log_valid (log_valid),
    .log_a     (log_a),
    .log_b     (log_b),
    .log_ctl   (log_ctl)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [7:0] a, logic [7:0] b, logic ap, logic bp,
                              logic [2:0] c, bit fx);
    exp_t e;
    int unsigned ao, bo, s;
    bit err;
    ao = c[2] ? ((32'd256 - {24'd0, a}) % 32'd256) : {24'd0, a};
    bo = c[1] ? ((32'd256 - {24'd0, b}) % 32'd256) : {24'd0, b};
    s  = ao + bo;
    err = (ap != ^a) || (bp != ^b) || ($countones(c) != 1);
    e.x = s[7:0];
    e.c = s[8];
    e.xerr = err || fx;
    e.yerr = err;
    e.a = a;
    e.b = b;
    e.ctl = c;
    return e;
  endfunction

  // Reference model and compare process.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mh = 0; erun = 0; crun = 0; mcnt = 0;
      mlog_v = 1'b0; mlog_a = '0; mlog_b = '0; mlog_c = '0;
    end else begin
      check("health", 32'(health), 32'(mh));
      check("err_cnt", 32'(err_cnt), 32'(mcnt));
      check("log_valid", 32'(log_valid), 32'(mlog_v));
      check("log_a", 32'(log_a), 32'(mlog_a));
      check("log_b", 32'(log_b), 32'(mlog_b));
      check("log_ctl", 32'(log_ctl), 32'(mlog_c));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_out: got out_valid=1, expected no pending result at %0t", $time);
        end else begin
          ce = q[0];
          xerr_e = ce.xerr || (mh == 2);
          yerr_e = ce.yerr || (mh == 2);
          check("x", 32'(bus.x), 32'(ce.x));
          check("y", 32'(bus.y), 32'(ce.x));
          check("xc", 32'(bus.xc), 32'(ce.c));
          check("yc", 32'(bus.yc), 32'(ce.c));
          check("xe", 32'(bus.xe), xerr_e ? 32'd3 : 32'd1);
          check("ye", 32'(bus.ye), yerr_e ? 32'd3 : 32'd1);
          if (bus.out_ready) begin
            void'(q.pop_front());
            n_deliv++;
            if (xerr_e || yerr_e) begin
              if (mcnt < 255) mcnt++;
`ifdef FT_ALU_ERRLOG_EN
              if (!mlog_v) begin
                mlog_v = 1'b1; mlog_a = ce.a; mlog_b = ce.b; mlog_c = ce.ctl;
              end
`endif
            end
            if (mh == 0) begin
              if (xerr_e || yerr_e) begin mh = 1; erun = 1; crun = 0; end
            end else if (mh == 1) begin
              if (xerr_e || yerr_e) begin
                crun = 0; erun++;
                if (erun >= 3) begin mh = 2; erun = 0; end
              end else begin
                erun = 0; crun++;
                if (crun >= 4) begin mh = 0; crun = 0; end
              end
            end
          end
        end
      end
      if (clr_fail) begin
        mh = 0; erun = 0; crun = 0; mcnt = 0;
        mlog_v = 1'b0; mlog_a = '0; mlog_b = '0; mlog_c = '0;
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(mk(bus.a, bus.b, bus.a_par, bus.b_par, bus.ctl, fault_x));
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ap,
                       input logic bp, input logic [2:0] c);
    bit ok;
    bus.a = a; bus.b = b; bus.a_par = ap; bus.b_par = bp; bus.ctl = c;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
      saw_stall = 1'b1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles, expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
    drive(a, b, ^a, ^b, c);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [7:0] rx, output logic rxc, output logic [1:0] rxe,
                            output logic [1:0] rye, output int lat);
    lat = 0; rx = '0; rxc = 1'b0; rxe = '0; rye = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i; rx = bus.x; rxc = bus.xc; rxe = bus.xe; rye = bus.ye;
        break;
      end
    end
    if (lat == 0) begin
      n_tests++; n_fail++;
      $display("FAIL result_timeout: got no out_valid in 20 cycles, expected a result");
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] rx;
  logic       rxc;
  logic [1:0] rxe, rye;
  int         lat, base;
  logic [2:0] ops [3];

  initial begin
    ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b100;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.a_par = 1'b0; bus.b_par = 1'b0;
    bus.ctl = 3'b001; bus.out_ready = 1'b1; clr_fail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_xc", 32'(bus.xc), 32'd0);
    check("rst_xe", 32'(bus.xe), 32'd1);
    check("rst_ye", 32'(bus.ye), 32'd1);
    check("rst_health", 32'(health), 32'd0);
    check("rst_log_valid", 32'(log_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Add
    one(8'h12, 8'h05, 3'b001);
    get_result(rx, rxc, rxe, rye, lat);
    check("add_latency", 32'(lat), 32'd2);
    check("add_x", 32'(rx), 32'h17);
    check("add_xc", 32'(rxc), 32'd0);
    check("add_xe", 32'(rxe), 32'd1);
    check("add_health", 32'(health), 32'd0);

    // Subtracts
    one(8'h12, 8'h05, 3'b010);
    get_result(rx, rxc, rxe, rye, lat);
    check("subb_x", 32'(rx), 32'h0D);
    check("subb_xc", 32'(rxc), 32'd1);
    check("subb_ye", 32'(rye), 32'd1);
    one(8'h12, 8'h05, 3'b100);
    get_result(rx, rxc, rxe, rye, lat);
    check("suba_x", 32'(rx), 32'hF3);
    check("suba_xc", 32'(rxc), 32'd0);

    // Input parity error, then clean run back to HEALTHY
    drive(8'h12, 8'h05, 1'b1, 1'b0, 3'b001);
    bus.in_valid = 1'b0;
    get_result(rx, rxc, rxe, rye, lat);
    check("perr_xe", 32'(rxe), 32'd3);
    check("perr_ye", 32'(rye), 32'd3);
    check("perr_health", 32'(health), 32'd1);
    check("perr_cnt", 32'(err_cnt), 32'd1);
`ifdef FT_ALU_ERRLOG_EN
    check("perr_log_valid", 32'(log_valid), 32'd1);
    check("perr_log_a", 32'(log_a), 32'h12);
`endif
    for (int i = 0; i < 4; i++) begin
      one(8'h12, 8'h05, 3'b001);
      get_result(rx, rxc, rxe, rye, lat);
      if (i == 2) check("clean3_health", 32'(health), 32'd1);
    end
    check("clean4_health", 32'(health), 32'd0);

    // Control errors to FAILED, then clear
    one(8'h12, 8'h05, 3'b011);
    get_result(rx, rxc, rxe, rye, lat);
    check("ctl011_xe", 32'(rxe), 32'd3);
    check("ctl011_cnt", 32'(err_cnt), 32'd2);
    one(8'h12, 8'h05, 3'b000);
    get_result(rx, rxc, rxe, rye, lat);
    check("ctl000_ye", 32'(rye), 32'd3);
    check("ctl000_health", 32'(health), 32'd1);
    one(8'h12, 8'h05, 3'b110);
    get_result(rx, rxc, rxe, rye, lat);
    check("ctl3_health", 32'(health), 32'd2);
    check("ctl3_cnt", 32'(err_cnt), 32'd4);
    one(8'h12, 8'h05, 3'b001);
    get_result(rx, rxc, rxe, rye, lat);
    check("failed_x", 32'(rx), 32'h17);
    check("failed_xe", 32'(rxe), 32'd3);
    check("failed_ye", 32'(rye), 32'd3);
    clr_fail = 1'b1;
    @(posedge clk); #1;
    clr_fail = 1'b0;
    check("clr_health", 32'(health), 32'd0);
    check("clr_cnt", 32'(err_cnt), 32'd0);
    one(8'h12, 8'h05, 3'b001);
    get_result(rx, rxc, rxe, rye, lat);
    check("post_clr_xe", 32'(rxe), 32'd1);

    // Backpressure stream
    base = n_deliv;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive(8'h30 + 8'(i * 7), 8'(8'h11 * i), ^(8'h30 + 8'(i * 7)), ^(8'(8'h11 * i)),
                ops[i % 3]);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 30 && n_deliv < base + 6; i++) @(posedge clk);
    #1;
    check("bp_delivered", 32'(n_deliv - base), 32'd6);
    check("bp_in_ready_dropped", 32'(saw_stall), 32'd1);
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Lane X duplicate carry-in stuck at 1
    force dut.u_lane_x.dup_cin = 1'b1;
    fault_x = 1'b1;
    one(8'h01, 8'h01, 3'b001);
    get_result(rx, rxc, rxe, rye, lat);
    release dut.u_lane_x.dup_cin;
    fault_x = 1'b0;
    check("fault_x", 32'(rx), 32'h02);
    check("fault_xe", 32'(rxe), 32'd3);
    check("fault_ye", 32'(rye), 32'd1);

    // Reset mid-stream
    drive(8'h21, 8'h03, ^8'h21, ^8'h03, 3'b001);
    drive(8'h44, 8'h04, ^8'h44, ^8'h04, 3'b010);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_health", 32'(health), 32'd0);
    check("midrst_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_out", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    one(8'h7F, 8'h01, 3'b001);
    get_result(rx, rxc, rxe, rye, lat);
    check("after_rst_x", 32'(rx), 32'h80);

    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
